// File: rtl/ff_checker_pkg.sv
// Shared types and constants for the D flip-flop response checker.
// Contents:
//   checker_state_t      - checker FSM states
//   DEFAULT_COUNT_WIDTH  - default width of the check/error counters
package ff_checker_pkg;

   localparam int DEFAULT_COUNT_WIDTH = 16;

   typedef enum logic [1:0] {
      UNSYNCED,
      CHECKING,
      FAILED
   } checker_state_t;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high clear
//   increment  in   add one this cycle (ignored once saturated)
//   count      out  current count, WIDTH bits
module saturating_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             increment,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (increment && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/flip_flop_checker.sv
// Response checker for a D flip-flop with active-low asynchronous clear.
// A reference register follows the flip-flop's reset/enable/d; once the
// reference value is defined every cycle compares q and q_n against it.
//
// Parameters:
//   COUNT_WIDTH    width of check_count / error_count
//   STOP_ON_ERROR  1: halt in FAILED on the first error
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   dut_reset_n, d, enable  flip-flop inputs as driven to it
//   q, q_n                  flip-flop outputs
//   synced                  reference model holds a known value
//   error                   sticky error flag
//   error_count             failed checks (saturating)
//   check_count             performed checks (saturating)
//   state_o                 FSM state, for debug/observation
// Optional (macro FF_CHECKER_SNAPSHOT_EN):
//   fail_cycle, fail_expected, fail_q, fail_q_n
//     check number and signals of the first failing check, frozen until reset
module flip_flop_checker
   import ff_checker_pkg::*;
#(
   parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
   parameter bit STOP_ON_ERROR = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   dut_reset_n,
   input  logic                   d,
   input  logic                   enable,
   input  logic                   q,
   input  logic                   q_n,
   output logic                   synced,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] error_count,
   output logic [COUNT_WIDTH-1:0] check_count,
   output checker_state_t         state_o
`ifdef FF_CHECKER_SNAPSHOT_EN
   ,
   output logic [COUNT_WIDTH-1:0] fail_cycle,
   output logic                   fail_expected,
   output logic                   fail_q,
   output logic                   fail_q_n
`endif
);

   checker_state_t state_q, state_d;
   logic           expected_q, expected_d;
   logic           error_q, error_d;
   logic           exp_now;
   logic           check_fail;
   logic           do_check;

   // The flip-flop clears asynchronously, so while its reset is low the
   // output must already be 0 in the same cycle.
   assign exp_now    = dut_reset_n ? expected_q : 1'b0;
   assign check_fail = (q != exp_now) || (q_n == q);
   assign do_check   = (state_q == CHECKING);

   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      error_d    = error_q;

      if (!dut_reset_n) begin
         expected_d = 1'b0;
      end else if (enable) begin
         expected_d = d;
      end

      case (state_q)
         UNSYNCED: begin
            if (!dut_reset_n || enable) begin
               state_d = CHECKING;
            end
         end
         CHECKING: begin
            if (check_fail) begin
               error_d = 1'b1;
               if (STOP_ON_ERROR) begin
                  state_d = FAILED;
               end
            end
         end
         FAILED:  state_d = FAILED;
         default: state_d = UNSYNCED;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= UNSYNCED;
         expected_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         error_q    <= error_d;
      end
   end

   // Both counters step in the same cycle and saturate at the same value,
   // which keeps error_count <= check_count.
   saturating_counter #(.WIDTH(COUNT_WIDTH)) u_check_counter (
      .clock     (clock),
      .reset     (reset),
      .increment (do_check),
      .count     (check_count)
   );

   saturating_counter #(.WIDTH(COUNT_WIDTH)) u_error_counter (
      .clock     (clock),
      .reset     (reset),
      .increment (do_check && check_fail),
      .count     (error_count)
   );

   assign synced  = (state_q != UNSYNCED);
   assign error   = error_q;
   assign state_o = state_q;

`ifdef FF_CHECKER_SNAPSHOT_EN
   logic [COUNT_WIDTH-1:0] fail_cycle_q, fail_cycle_d;
   logic                   fail_expected_q, fail_q_q, fail_q_n_q;
   logic                   capture;

   // error_q low means no failing check has been seen yet; the recorded
   // cycle is the check number including the failing check itself.
   assign capture = do_check && check_fail && !error_q;

   always_comb begin
      fail_cycle_d = check_count;
      if (check_count != {COUNT_WIDTH{1'b1}}) begin
         fail_cycle_d = check_count + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fail_cycle_q    <= '0;
         fail_expected_q <= 1'b0;
         fail_q_q        <= 1'b0;
         fail_q_n_q      <= 1'b0;
      end else if (capture) begin
         fail_cycle_q    <= fail_cycle_d;
         fail_expected_q <= exp_now;
         fail_q_q        <= q;
         fail_q_n_q      <= q_n;
      end
   end

   assign fail_cycle    = fail_cycle_q;
   assign fail_expected = fail_expected_q;
   assign fail_q        = fail_q_q;
   assign fail_q_n      = fail_q_n_q;
`endif

endmodule

// File: tb/tb_flip_flop_checker.sv
// Bench for flip_flop_checker. Three checker instances (normal, stop-on-error,
// 4-bit counters) watch one shared flip-flop stream. A behavioural model
// tracks each checker from the operating rules; a negedge process compares
// every output every cycle, and directed literal checks pin the model.
module tb_flip_flop_checker;
   import ff_checker_pkg::*;

   localparam int N = 3;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset, dut_reset_n, d, enable, q, q_n;
   logic force_q_en, force_q_val, force_qn_eq_q;
   logic ff_q = 1'b1;   // correct flip-flop, powered up to an arbitrary value
   logic q_good;

   always @(posedge clock) begin
      if (!dut_reset_n)  ff_q <= 1'b0;
      else if (enable)   ff_q <= d;
   end

   always_comb begin
      q_good = dut_reset_n ? ff_q : 1'b0;
      q      = force_q_en ? force_q_val : q_good;
      q_n    = force_qn_eq_q ? q : ~q;
   end

   // ---------------- DUTs ----------------
   logic           syn0, syn1, syn2, er0, er1, er2;
   logic [15:0]    cc0, ec0, cc1, ec1;
   logic [3:0]     cc2, ec2;
   checker_state_t st0, st1, st2;
`ifdef FF_CHECKER_SNAPSHOT_EN
   logic [15:0] fc0, fc1;
   logic [3:0]  fc2;
   logic        fe0, fq0, fqn0, fe1, fq1, fqn1, fe2, fq2, fqn2;
`endif

   flip_flop_checker #(.COUNT_WIDTH(16), .STOP_ON_ERROR(1'b0)) u_main (
      .clock(clock), .reset(reset), .dut_reset_n(dut_reset_n), .d(d),
      .enable(enable), .q(q), .q_n(q_n), .synced(syn0), .error(er0),
      .error_count(ec0), .check_count(cc0), .state_o(st0)
`ifdef FF_CHECKER_SNAPSHOT_EN
      , .fail_cycle(fc0), .fail_expected(fe0), .fail_q(fq0), .fail_q_n(fqn0)
`endif
   );

   flip_flop_checker #(.COUNT_WIDTH(16), .STOP_ON_ERROR(1'b1)) u_stop (
      .clock(clock), .reset(reset), .dut_reset_n(dut_reset_n), .d(d),
      .enable(enable), .q(q), .q_n(q_n), .synced(syn1), .error(er1),
      .error_count(ec1), .check_count(cc1), .state_o(st1)
`ifdef FF_CHECKER_SNAPSHOT_EN
      , .fail_cycle(fc1), .fail_expected(fe1), .fail_q(fq1), .fail_q_n(fqn1)
`endif
   );

   flip_flop_checker #(.COUNT_WIDTH(4), .STOP_ON_ERROR(1'b0)) u_small (
      .clock(clock), .reset(reset), .dut_reset_n(dut_reset_n), .d(d),
      .enable(enable), .q(q), .q_n(q_n), .synced(syn2), .error(er2),
      .error_count(ec2), .check_count(cc2), .state_o(st2)
`ifdef FF_CHECKER_SNAPSHOT_EN
      , .fail_cycle(fc2), .fail_expected(fe2), .fail_q(fq2), .fail_q_n(fqn2)
`endif
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int maxv [N] = '{65535, 65535, 15};
   bit stopv[N] = '{1'b0, 1'b1, 1'b0};
   int m_chk[N], m_err[N], m_fcyc[N];
   bit m_sync[N], m_failed[N], m_errf[N], m_fexp[N], m_fq[N], m_fqn[N];
   bit m_ref;

   initial begin
      m_ref = 1'b0;
      for (int k = 0; k < N; k++) begin
         m_chk[k] = 0; m_err[k] = 0; m_fcyc[k] = 0;
         m_sync[k] = 0; m_failed[k] = 0; m_errf[k] = 0;
         m_fexp[k] = 0; m_fq[k] = 0; m_fqn[k] = 0;
      end
   end

   always @(posedge clock) begin
      bit exp_now, bad_now;
      exp_now = dut_reset_n ? m_ref : 1'b0;
      bad_now = (q !== exp_now) || (q_n === q);
      if (reset) begin
         m_ref = 1'b0;
         for (int k = 0; k < N; k++) begin
            m_chk[k] = 0; m_err[k] = 0; m_fcyc[k] = 0;
            m_sync[k] = 0; m_failed[k] = 0; m_errf[k] = 0;
            m_fexp[k] = 0; m_fq[k] = 0; m_fqn[k] = 0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!m_sync[k]) begin
               if (!dut_reset_n || enable) m_sync[k] = 1'b1;
            end else if (!m_failed[k]) begin
               if (m_chk[k] < maxv[k]) m_chk[k]++;
               if (bad_now) begin
                  if (!m_errf[k]) begin
                     m_fcyc[k] = m_chk[k];
                     m_fexp[k] = exp_now;
                     m_fq[k]   = q;
                     m_fqn[k]  = q_n;
                  end
                  if (m_err[k] < maxv[k]) m_err[k]++;
                  m_errf[k] = 1'b1;
                  if (stopv[k]) m_failed[k] = 1'b1;
               end
            end
         end
         if (!dut_reset_n)  m_ref = 1'b0;
         else if (enable)   m_ref = d;
      end
   end

   function automatic int model_state(input int k);
      if (m_failed[k])    return int'(FAILED);
      else if (m_sync[k]) return int'(CHECKING);
      else                return int'(UNSYNCED);
   endfunction

   task automatic cmp(input int k, input logic s, input logic e,
                      input logic [31:0] cc, input logic [31:0] ec,
                      input logic [31:0] st);
      check($sformatf("dut%0d synced", k), {31'b0, s}, int'(m_sync[k]));
      check($sformatf("dut%0d error", k), {31'b0, e}, int'(m_errf[k]));
      check($sformatf("dut%0d check_count", k), cc, m_chk[k]);
      check($sformatf("dut%0d error_count", k), ec, m_err[k]);
      check($sformatf("dut%0d state", k), st, model_state(k));
   endtask

`ifdef FF_CHECKER_SNAPSHOT_EN
   task automatic cmp_snap(input int k, input logic [31:0] fc, input logic fe,
                           input logic fq, input logic fqn);
      check($sformatf("dut%0d fail_cycle", k), fc, m_fcyc[k]);
      check($sformatf("dut%0d fail_expected", k), {31'b0, fe}, int'(m_fexp[k]));
      check($sformatf("dut%0d fail_q", k), {31'b0, fq}, int'(m_fq[k]));
      check($sformatf("dut%0d fail_q_n", k), {31'b0, fqn}, int'(m_fqn[k]));
   endtask
`endif

   always @(negedge clock) begin
      cmp(0, syn0, er0, {16'b0, cc0}, {16'b0, ec0}, {30'b0, st0});
      cmp(1, syn1, er1, {16'b0, cc1}, {16'b0, ec1}, {30'b0, st1});
      cmp(2, syn2, er2, {28'b0, cc2}, {28'b0, ec2}, {30'b0, st2});
`ifdef FF_CHECKER_SNAPSHOT_EN
      cmp_snap(0, {16'b0, fc0}, fe0, fq0, fqn0);
      cmp_snap(1, {16'b0, fc1}, fe1, fq1, fqn1);
      cmp_snap(2, {28'b0, fc2}, fe2, fq2, fqn2);
`endif
   end

   // ---------------- driver ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic en, input logic dv);
      enable = en;
      d      = dv;
   endtask

   initial begin
      reset = 1'b1; dut_reset_n = 1'b1; enable = 1'b0; d = 1'b0;
      force_q_en = 1'b0; force_q_val = 1'b0; force_qn_eq_q = 1'b0;
      cycles(2);
      check("reset synced", {31'b0, syn0}, 0);
      check("reset check_count", {16'b0, cc0}, 0);

      // unsynced: nothing known, nothing checked
      reset = 1'b0;
      drive(1'b0, 1'b0);
      cycles(5);
      check("unsynced synced", {31'b0, syn0}, 0);
      check("unsynced check_count", {16'b0, cc0}, 0);
      check("unsynced error", {31'b0, er0}, 0);

      // sync cycle: state moves, but no check on that edge
      dut_reset_n = 1'b0;
      cycles(1);
      dut_reset_n = 1'b1;
      check("sync synced", {31'b0, syn0}, 1);
      check("sync check_count", {16'b0, cc0}, 0);

      drive(1'b1, 1'b1); cycles(10);
      drive(1'b1, 1'b0); cycles(10);
      drive(1'b0, 1'b1); cycles(10);
      drive(1'b0, 1'b0); cycles(10);
      check("clean check_count", {16'b0, cc0}, 40);
      check("clean error_count", {16'b0, ec0}, 0);
      check("clean error", {31'b0, er0}, 0);
      check("small saturated", {28'b0, cc2}, 15);

      // q stuck at 1 while loading 0
      drive(1'b1, 1'b0);
      force_q_en = 1'b1; force_q_val = 1'b1;
      cycles(1);
      check("stuck error first edge", {31'b0, er0}, 1);
      check("stuck error_count first", {16'b0, ec0}, 1);
      check("stop state", {30'b0, st1}, int'(FAILED));
      check("stop check_count", {16'b0, cc1}, 41);
      cycles(2);
      force_q_en = 1'b0;
      check("stuck error_count", {16'b0, ec0}, 3);

      // q_n equal to q with a correct q
      force_qn_eq_q = 1'b1;
      cycles(1);
      force_qn_eq_q = 1'b0;
      check("qn error_count", {16'b0, ec0}, 4);

      drive(1'b0, 1'b0);
      cycles(10);
      check("stop frozen check_count", {16'b0, cc1}, 41);
      check("stop frozen error_count", {16'b0, ec1}, 1);
      check("stop still failed", {30'b0, st1}, int'(FAILED));
      check("main check_count", {16'b0, cc0}, 54);
`ifdef FF_CHECKER_SNAPSHOT_EN
      check("snap1 fail_cycle", {16'b0, fc0}, 41);
      check("snap1 fail_q_n", {31'b0, fqn0}, 0);
`endif

      // reset together with a mismatch: reset wins
      reset = 1'b1; force_q_en = 1'b1; force_q_val = 1'b1;
      cycles(1);
      force_q_en = 1'b0; reset = 1'b0;
      check("reset-wins error", {31'b0, er0}, 0);
      check("reset-wins error_count", {16'b0, ec0}, 0);
      check("reset-wins synced", {31'b0, syn0}, 0);

      // reset and enable together: expected 0
      dut_reset_n = 1'b0; drive(1'b1, 1'b1);
      cycles(1);
      dut_reset_n = 1'b1; drive(1'b0, 1'b0);
      cycles(4);
      force_q_en = 1'b1; force_q_val = 1'b1;   // fifth check fails
      cycles(1);
      force_q_en = 1'b0;
      cycles(15);
      check("run2 check_count", {16'b0, cc0}, 20);
      check("run2 error_count", {16'b0, ec0}, 1);
      check("run2 small check_count", {28'b0, cc2}, 15);
      check("run2 small error_count", {28'b0, ec2}, 1);
      check("run2 stop check_count", {16'b0, cc1}, 5);
`ifdef FF_CHECKER_SNAPSHOT_EN
      check("snap2 fail_cycle", {16'b0, fc0}, 5);
      check("snap2 fail_expected", {31'b0, fe0}, 0);
      check("snap2 fail_q", {31'b0, fq0}, 1);
`endif

      cycles(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
